// File: rtl/interrupt_acknowledge_control_pkg.sv
// Shared types, OCW2 command codes and level helpers
// for the 8259A acknowledge / in-service path.
package KF8259_Common_Package;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK1,
    ST_ACK2,
    ST_ACK3
  } inta_state_t;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  function automatic logic [7:0] num2bit(
    input logic [2:0] num
  );
    return 8'b0000_0001 << num;
  endfunction

  function automatic logic [2:0] bit2num(
    input logic [7:0] onehot
  );
    logic [2:0] n;
    n = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (onehot[i]) n = i[2:0];
    return n;
  endfunction

  function automatic logic [7:0] rotate_right(
    input logic [7:0] src,
    input logic [2:0] rot
  );
    logic [15:0] dbl;
    dbl = {src, src} >> ({1'b0, rot} + 4'd1);
    return dbl[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(
    input logic [7:0] src,
    input logic [2:0] rot
  );
    logic [15:0] dbl;
    dbl = {src, src} << ({1'b0, rot} + 4'd1);
    return dbl[15:8];
  endfunction

  function automatic logic [7:0] resolve_priority(
    input logic [7:0] req
  );
    return req & (~req + 8'd1);
  endfunction

endpackage

// File: rtl/interrupt_acknowledge_control_inta_edge_detect.sv
// INTA# history register with rising and
// falling edge strobes.
module inta_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic inta_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= inta_n_i;
  end

  assign fall_o = prev_q & ~inta_n_i;
  assign rise_o = ~prev_q & inta_n_i;

endmodule

// File: rtl/interrupt_acknowledge_control.sv
// INT/INTA sequencing, vector bytes and EOI /
// rotate control toward the in-service register.
module interrupt_acknowledge_control
  import KF8259_Common_Package::*;
#(
  parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  interrupt,
  input  logic        interrupt_acknowledge_n,
  input  logic        u8086_mode,
  input  logic        auto_eoi_config,
  input  logic [10:0] interrupt_vector_address,
  input  logic        write_ocw2,
  input  logic [7:0]  internal_data_bus,
  input  logic [7:0]  highest_level_in_service,
  output logic        interrupt_to_cpu,
  output logic        latch_in_service,
  output logic [7:0]  clear_interrupt_request,
  output logic [7:0]  end_of_interrupt,
  output logic [2:0]  priority_rotate,
  output logic        out_control_logic_data,
  output logic [7:0]  control_logic_data
);

  logic inta_fall, inta_rise;

  inta_edge_detect u_edge (
    .clock    (clock),
    .reset    (reset),
    .inta_n_i (interrupt_acknowledge_n),
    .fall_o   (inta_fall),
    .rise_o   (inta_rise)
  );

  inta_state_t state_q, next_st;
  logic        mode_q;
  logic        rot_aeoi_q;
  logic [7:0]  acked_q;

  logic [2:0] ocw_cmd, ocw_lvl;
  logic [7:0] ocw_eoi_d;
  logic       ocw_rot_en_d;
  logic [2:0] ocw_rot_d;
  logic       flag_set_d, flag_clr_d;
  logic       unused_bus;

  assign ocw_cmd    = internal_data_bus[7:5];
  assign ocw_lvl    = internal_data_bus[2:0];
  assign unused_bus = ^internal_data_bus[4:3];

  always_comb begin
    ocw_eoi_d    = 8'h00;
    ocw_rot_en_d = 1'b0;
    ocw_rot_d    = 3'd0;
    flag_set_d   = 1'b0;
    flag_clr_d   = 1'b0;
    if (write_ocw2) begin
      unique case (ocw_cmd)
        OCW2_NS_EOI:
          ocw_eoi_d = highest_level_in_service;
        OCW2_SP_EOI:
          ocw_eoi_d = num2bit(ocw_lvl);
        OCW2_ROT_NS_EOI: begin
          ocw_eoi_d    = highest_level_in_service;
          ocw_rot_en_d = |highest_level_in_service;
          ocw_rot_d    = bit2num(highest_level_in_service);
        end
        OCW2_ROT_SP_EOI: begin
          ocw_eoi_d    = num2bit(ocw_lvl);
          ocw_rot_en_d = 1'b1;
          ocw_rot_d    = ocw_lvl;
        end
        OCW2_SET_PRI: begin
          ocw_rot_en_d = 1'b1;
          ocw_rot_d    = ocw_lvl;
        end
        OCW2_ROT_AEOI_SET: flag_set_d = 1'b1;
        OCW2_ROT_AEOI_CLR: flag_clr_d = 1'b1;
        default: ;
      endcase
    end
  end

  // A spurious acknowledge is served as IR7
  logic [7:0] cap_level;
  logic       byte_mode;
  logic [2:0] acked_num;
  logic [7:0] byte_d;
  logic       byte_en_d;
  logic       last_rise, aeoi_fire;

  assign cap_level = (interrupt == 8'h00) ? 8'h80
                                          : interrupt;
  assign byte_mode = (state_q == ST_IDLE) ? u8086_mode
                                          : mode_q;
  assign acked_num = bit2num(acked_q);

  always_comb begin
    byte_en_d = 1'b1;
    byte_d    = 8'h00;
    unique case (state_q)
      ST_IDLE, ST_ACK1:
        if (byte_mode) byte_en_d = 1'b0;
        else           byte_d    = CALL_OPCODE;
      ST_ACK2:
        byte_d = byte_mode
          ? {interrupt_vector_address[10:6], acked_num}
          : {interrupt_vector_address[2:0], acked_num,
             2'b00};
      ST_ACK3:
        byte_d = interrupt_vector_address[10:3];
      default: ;
    endcase
  end

  always_comb begin
    next_st = state_q;
    unique case (state_q)
      ST_ACK1: next_st = ST_ACK2;
      ST_ACK2: next_st = mode_q ? ST_IDLE : ST_ACK3;
      ST_ACK3: next_st = ST_IDLE;
      default: next_st = ST_IDLE;
    endcase
  end

  assign last_rise = inta_rise &&
    ((state_q == ST_ACK2 && mode_q) ||
     state_q == ST_ACK3);
  assign aeoi_fire = last_rise && auto_eoi_config;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                 <= ST_IDLE;
      mode_q                  <= 1'b0;
      rot_aeoi_q              <= 1'b0;
      acked_q                 <= 8'h00;
      interrupt_to_cpu        <= 1'b0;
      latch_in_service        <= 1'b0;
      clear_interrupt_request <= 8'h00;
      end_of_interrupt        <= 8'h00;
      priority_rotate         <= 3'b111;
      out_control_logic_data  <= 1'b0;
      control_logic_data      <= 8'h00;
    end else begin
      latch_in_service        <= 1'b0;
      clear_interrupt_request <= 8'h00;
      end_of_interrupt <= ocw_eoi_d |
        (aeoi_fire ? acked_q : 8'h00);

      if (flag_set_d)      rot_aeoi_q <= 1'b1;
      else if (flag_clr_d) rot_aeoi_q <= 1'b0;

      if (ocw_rot_en_d)
        priority_rotate <= ocw_rot_d;
      else if (aeoi_fire && rot_aeoi_q)
        priority_rotate <= acked_num;

      unique case (state_q)
        ST_IDLE: begin
          interrupt_to_cpu <= |interrupt;
          if (inta_fall) begin
            state_q                 <= ST_ACK1;
            mode_q                  <= u8086_mode;
            acked_q                 <= cap_level;
            latch_in_service        <= 1'b1;
            clear_interrupt_request <= cap_level;
            interrupt_to_cpu        <= 1'b0;
            out_control_logic_data  <= byte_en_d;
            control_logic_data      <= byte_d;
          end
        end
        default: begin
          interrupt_to_cpu <= 1'b0;
          if (inta_fall) begin
            out_control_logic_data <= byte_en_d;
            control_logic_data     <= byte_d;
          end
          if (inta_rise) begin
            state_q                <= next_st;
            out_control_logic_data <= 1'b0;
            control_logic_data     <= 8'h00;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/interrupt_acknowledge_control.md
# interrupt_acknowledge_control

CPU-facing end of the 8259A in-service path. Raises the interrupt line to the CPU when the priority resolver presents a winning request, sequences the INTA# pulses (8086: two, 8080: three), and drives the vector/CALL bytes onto the data bus. Issues the `latch_in_service`, `end_of_interrupt` and `priority_rotate` controls that the in-service register consumes, from automatic EOI and from OCW2 commands.

## Interface
- `CALL_OPCODE`, 8'hCD, first byte returned in 8080 mode.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `interrupt`  in  8  one-hot winning request from the priority resolver; 0 = none.
- `interrupt_acknowledge_n`  in  1  INTA#, already synchronized to `clock`.
- `u8086_mode`  in  1  1 = 8086 (two INTA), 0 = 8080 (three INTA).
- `auto_eoi_config`  in  1  AEOI enabled (ICW4).
- `interrupt_vector_address`  in  11  ICW bits A15..A5; 8086 uses [10:6] as T7..T3.
- `write_ocw2`  in  1  one-cycle OCW2 write strobe.
- `internal_data_bus`  in  8  OCW2 byte: [7:5] = R,SL,EOI; [2:0] = L.
- `highest_level_in_service`  in  8  one-hot from the in-service register.
- `interrupt_to_cpu`  out  1  INT.
- `latch_in_service`  out  1  one-cycle pulse.
- `clear_interrupt_request`  out  8  one-hot one-cycle pulse to IRR.
- `end_of_interrupt`  out  8  one-cycle clear mask to the ISR.
- `priority_rotate`  out  3  lowest-priority level.
- `out_control_logic_data`  out  1  data bus drive enable.
- `control_logic_data`  out  8  byte driven during INTA.

## Operation
- INTA edges: register `interrupt_acknowledge_n` as `prev`. Falling edge: prev=1, now=0. Rising edge: prev=0, now=1.
- FSM states: IDLE, ACK1, ACK2, ACK3.
- IDLE:
  - `interrupt_to_cpu` <= 1 while `interrupt` != 0.
  - On a falling edge, go to ACK1, capture `acked_level` = `interrupt`, or 8'h80 if `interrupt` is 0 (spurious → IR7).
  - Pulse `latch_in_service` and `clear_interrupt_request` = `acked_level`.
  - Clear `interrupt_to_cpu`.
- Each rising edge advances the FSM one state:
  - 8086: ACK1→ACK2→IDLE.
  - 8080: ACK1→ACK2→ACK3→IDLE.
- Data bytes, driven only while INTA# is low in that state:
  - 8086 ACK1: enable 0.
  - 8086 ACK2: {A[10:6], num(acked_level)}.
  - 8080 ACK1: CALL_OPCODE.
  - 8080 ACK2: {A[2:0], num, 2'b00}.
  - 8080 ACK3: A[10:3].
- AEOI: on the final rising edge with `auto_eoi_config`=1, `end_of_interrupt` = `acked_level` for one cycle.
  - If rotate-in-AEOI flag is set, `priority_rotate` <= num(acked_level).
- OCW2 decode of {R,SL,EOI}:
  - 001: EOI = `highest_level_in_service`.
  - 011: EOI = 1<<L.
  - 101: EOI = highest; rotate = num(highest). No rotate if highest = 0.
  - 111: EOI = 1<<L; rotate = L.
  - 110: rotate = L.
  - 100: set rotate-in-AEOI flag.
  - 000: clear rotate-in-AEOI flag.
  - 010: no operation.
- Simultaneous OCW2 EOI and AEOI: `end_of_interrupt` = OR of both masks; OCW2 rotate wins.
- Mode change mid-sequence: `u8086_mode` is sampled at ACK1 entry and held to IDLE.

## Timing
- Reset values:
  - FSM IDLE.
  - `interrupt_to_cpu`, `latch_in_service`, `out_control_logic_data` = 0.
  - `control_logic_data`, `clear_interrupt_request`, `end_of_interrupt` = 0.
  - `priority_rotate` = 3'b111 (IR0 highest); rotate flag = 0.
- Reset mid-sequence aborts to IDLE next cycle with no AEOI.
- `latch_in_service` and `clear_interrupt_request` assert the cycle after the falling edge is detected (registered).
- `interrupt_to_cpu` deasserts the same cycle.
- `out_control_logic_data` asserts the cycle after a falling edge and drops the cycle after the rising edge.
- EOI pulses are registered: valid one cycle after the triggering rising edge or `write_ocw2`. Width is exactly one cycle.

## Structure
- Shared items go in KF8259_Common_Package:
  - FSM state typedef.
  - OCW2 command constants.
  - Functions `num2bit`, `bit2num`, plus the existing rotate/resolve functions.
- One sub-module: `inta_edge_detect` (prev register plus rise/fall strobes).

## Test plan
- 8086, T=5'b01000, `interrupt`=8'h08, two INTA pulses:
  - INT rises, then falls at INTA1; `latch_in_service` and `clear_interrupt_request`=8'h08 pulse once.
  - Byte 8'h43 driven during INTA2.
- 8080, A=11'h123, `interrupt`=8'h02:
  - Bytes in order: 8'hCD, then 8'h64, then 8'h24.
  - Enable low between pulses.
- 8086 AEOI with rotate flag set, `interrupt`=8'h20: after INTA2 rises, `end_of_interrupt`=8'h20 for one cycle and `priority_rotate`=5.
- OCW2 8'hE3 with highest=8'h10: `end_of_interrupt`=8'h08, `priority_rotate`=3.
- OCW2 8'hA0 with highest=8'h10: `end_of_interrupt`=8'h10, `priority_rotate`=4.
- Spurious INTA with `interrupt`=0: `clear_interrupt_request`=8'h80; 8086 vector low bits = 7.
- Reset asserted between INTA1 and INTA2: all outputs at reset values, FSM IDLE, no EOI.
